// File: rtl/input_debouncer.sv
// input_debouncer: synchronises a raw, possibly bouncing input into the clk
// domain and only lets a new level through once it has been seen on
// DEBOUNCE_CYCLES consecutive clock samples. Produces a clean level (q),
// one-cycle rise/fall strobes, and a busy flag while a change is qualifying.
module input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  // Stability counter width, derived from the qualification length.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Counter value at which the current sample completes qualification.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic q_q, q_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic busy_q, busy_d;

  // Synchroniser chain: d_in enters at bit 0, the oldest sample leaves at the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
    end
  end

  // Only the last synchroniser stage is ever looked at by the filter.
  assign sync = sync_q[SYNC_STAGES-1];

  // Next-state and counter logic; a bounce back to the settled level
  // abandons the qualification and clears the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_LOW: begin
        if (sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = S_HIGH;
            cnt_d   = '0;
          end else begin
            state_d = S_WAIT_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      S_WAIT_HI: begin
        if (!sync) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = S_LOW;
            cnt_d   = '0;
          end else begin
            state_d = S_WAIT_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      S_WAIT_LO: begin
        if (sync) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs change on
  // the same edge as the state; strobes fire when the level flips.
  always_comb begin
    q_d    = (state_d == S_HIGH) || (state_d == S_WAIT_LO);
    busy_d = (state_d == S_WAIT_HI) || (state_d == S_WAIT_LO);
    rise_d = q_d && !q_q;
    fall_d = !q_d && q_q;
  end

  // State, counter and output registers; reset wins over everything and
  // never produces a strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule
